// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter: FSM encodings, requester IDs
// and the default burst length.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam int LINE_BEATS_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant between I-cache and D-cache; on a tie the
// requester that did not win last time is chosen.
module mem_arbiter_rr
    import mem_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_req,
    input  logic    d_req,
    input  logic    grant_en,
    output req_id_t grant
);

    req_id_t last_grant;

    always_comb begin
        grant = REQ_I;
        if (i_req && d_req) begin
            grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (d_req) begin
            grant = REQ_D;
        end
    end

    // Reset to I so that D takes the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_I;
        end else if (grant_en) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the off-core memory bus between I-cache refill and D-cache
// refill/writeback, one LINE_BEATS burst at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = LINE_BEATS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wnext,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wen,
    output logic [7:0]        bus_len,
    input  logic              bus_ack,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_wready,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_last,
    output logic              stallreq_for_cache
);

    localparam int              CNT_W    = $clog2(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_BEATS - 1);

    state_t           state;
    state_t           state_nxt;
    req_id_t          owner;
    req_id_t          grant;
    logic [CNT_W-1:0] beat_cnt;
    logic             grant_en;
    logic             owner_d;
    logic             wen;
    logic             in_data;
    logic             beat;
    logic             final_beat;

    assign grant_en = (state == ST_IDLE) && (i_req || d_req);

    mem_arbiter_rr u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .d_req    (d_req),
        .grant_en (grant_en),
        .grant    (grant)
    );

    assign owner_d    = (owner == REQ_D);
    assign wen        = owner_d && d_wen;
    assign in_data    = (state == ST_DATA);
    // A beat is the handshake matching the burst direction; the other strobe is noise.
    assign beat       = in_data && (wen ? bus_wready : bus_rvalid);
    assign final_beat = beat && (beat_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_req || d_req) state_nxt = ST_ADDR;
            ST_ADDR: if (bus_ack)        state_nxt = ST_DATA;
            ST_DATA: if (final_beat)     state_nxt = ST_DONE;
            ST_DONE:                     state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= REQ_I;
        end else if (grant_en) begin
            owner <= grant;
        end
    end

    // Counter clears outside DATA so an abandoned or finished burst never leaks a count.
    always_ff @(posedge clk) begin
        if (rst || !in_data) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= final_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    always_comb begin
        bus_req   = (state == ST_ADDR);
        bus_addr  = '0;
        bus_wen   = 1'b0;
        if (state == ST_ADDR || state == ST_DATA) begin
            bus_addr = owner_d ? d_addr : i_addr;
            bus_wen  = wen;
        end
        bus_len   = 8'(LINE_BEATS - 1);
        bus_wdata = d_wdata;

        i_rvalid  = bus_rvalid && in_data && !wen && !owner_d;
        d_rvalid  = bus_rvalid && in_data && !wen && owner_d;
        i_rdata   = bus_rdata;
        d_rdata   = bus_rdata;
        d_wnext   = bus_wready && in_data && owner_d && d_wen;

        i_done    = (state == ST_DONE) && !owner_d;
        d_done    = (state == ST_DONE) && owner_d;

        stallreq_for_cache = (state != ST_IDLE) || i_req || d_req;
    end

`ifndef SYNTHESIS
    // The bridge's last marker is only cross-checked; the local counter decides burst end.
    logic last_mismatch;
    logic last_err;

    assign last_mismatch = beat && (bus_last != (beat_cnt == LAST_CNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_err <= 1'b0;
        end else if (last_mismatch) begin
            last_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(last_mismatch && !last_err))
            else $error("mem_arbiter: bus_last disagrees with beat counter");
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single off-core memory bus between I-cache refill and D-cache refill/writeback.
- Sequences one burst transaction at a time: address phase, then LINE_BEATS data beats.
- Raises stallreq_for_cache to the pipeline stall controller while any cache transaction is pending or in flight.
- Sits between the two caches and the bus bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, beat width
LINE_BEATS, 4, beats per burst (power of two, 2..16)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_req  in  1  I-cache line read request, held until i_done
i_addr  in  ADDR_W  I-cache line address, stable while i_req
i_rvalid  out  1  read beat valid to I-cache
i_rdata  out  DATA_W  read beat data
i_done  out  1  one-cycle completion pulse
d_req  in  1  D-cache request, held until d_done
d_wen  in  1  1 = writeback, 0 = refill; stable while d_req
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  DATA_W  current write beat
d_wnext  out  1  write beat accepted; D-cache advances to the next beat
d_rvalid  out  1  read beat valid to D-cache
d_rdata  out  DATA_W  read beat data
d_done  out  1  one-cycle completion pulse
bus_req  out  1  address-phase request
bus_addr  out  ADDR_W  burst address
bus_wen  out  1  burst direction
bus_len  out  8  LINE_BEATS-1
bus_ack  in  1  address accepted
bus_rvalid  in  1  read beat valid
bus_rdata  in  DATA_W  read beat
bus_wready  in  1  write beat accepted
bus_wdata  out  DATA_W  write beat (= d_wdata)
bus_last  in  1  final beat marker (checked only)
stallreq_for_cache  out  1  pipeline stall request

Behaviour:
- FSM states:
  - IDLE -> ADDR when i_req|d_req.
  - ADDR -> DATA on bus_ack.
  - DATA -> DONE on final beat.
  - DONE -> IDLE unconditionally.
- Grant (IDLE only):
  - Single requester wins.
  - If both request, the requester not equal to last_grant wins (round-robin).
  - last_grant resets to I, so D wins the first tie.
  - Owner and last_grant are latched on the IDLE->ADDR edge.
- ADDR:
  - bus_req=1; bus_addr/bus_wen come from the owner (bus_wen=0 for I).
  - bus_len=LINE_BEATS-1, constant.
  - Held until bus_ack, with no timeout.
- DATA:
  - beat_cnt (clog2(LINE_BEATS) bits) starts at 0.
  - It increments on bus_rvalid (read) or bus_wready (write).
  - The final beat is the handshake with beat_cnt==LINE_BEATS-1; no wrap.
  - Beats are forwarded combinationally, zero latency:
    - owner_rvalid = bus_rvalid & state==DATA & ~wen
    - d_wnext = bus_wready & state==DATA & owner==D & d_wen
  - The non-owner's rvalid is always 0.
  - Read data outputs mirror bus_rdata unconditionally.
- DONE:
  - Owner's done=1 for exactly one cycle; all requests are ignored.
  - Requesters drop req at the edge after done, so IDLE never re-grants a finished request.
- stallreq_for_cache = (state!=IDLE) | i_req | d_req.
  - Combinational, so it asserts in the same cycle a request appears.
  - Falls in the first IDLE cycle after DONE if no new request is pending.
- bus_last mismatch: a beat with bus_last disagreeing with the counter sets a sticky simulation-only assertion. The counter remains authoritative.
- Reset values: state=IDLE, beat_cnt=0, owner=I, last_grant=I. All outputs are 0 except data buses (don't-care) and bus_len (constant).
- Reset mid-transaction abandons the burst; the bus bridge is reset on the same rst.
- Bus signals ignored outside the expected state: bus_ack outside ADDR, and bus_rvalid/bus_wready outside DATA.

Decomposition:
- Shared defines file: state encodings (2 bits), requester IDs (I=0, D=1), and a default LINE_BEATS constant.
- One natural sub-module, mem_arbiter_rr: a 2-way round-robin grant with last_grant register, instantiated once.
- FSM, beat counter and muxing stay in the top module.

Test Plan:
- Single I read: i_req=1, bus_ack on cycle 2, four bus_rvalid beats 0xA0..0xA3.
  -> i_rvalid ×4 with matching data, i_done one cycle after the 4th beat, d_rvalid stays 0, stall high throughout.
- Tie after reset: i_req and d_req asserted together.
  -> D granted first (bus_addr=d_addr), I granted in the next IDLE, and the grant order alternates on repeated ties.
- D writeback with bus_wready stalled 3 cycles between beats.
  -> d_wnext pulses exactly 4 times, bus_wen=1, d_done after the 4th accepted beat.
- Held address phase: bus_ack withheld 10 cycles.
  -> bus_req, bus_addr and bus_wen stay stable, no beats counted, stall stays 1.
- Reset in DATA after 2 beats.
  -> Next cycle state=IDLE, bus_req=0, done=0, beat_cnt=0. A fresh request re-runs all 4 beats.
- Spurious bus_rvalid in IDLE and ADDR.
  -> No rvalid forwarded, counter unchanged.
